// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - Handshake, result, redirect and statistics bundle for branch_resolve.
interface branch_resolve_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic [31:0] in_rs1;
    logic [2:0]  in_funct3;
    logic        in_is_branch;
    logic        in_is_jal;
    logic        in_is_jalr;
    logic [1:0]  in_comp;
    logic        in_pred_taken;
    logic [31:0] in_pred_target;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [31:0] out_target;
    logic [31:0] out_link;
    logic        out_illegal;
    logic        out_misalign;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    modport master (
        output in_valid, in_pc, in_imm, in_rs1, in_funct3, in_is_branch, in_is_jal,
               in_is_jalr, in_comp, in_pred_taken, in_pred_target, out_ready,
        input  in_ready, out_valid, out_taken, out_target, out_link, out_illegal,
               out_misalign, redirect_valid, redirect_pc, flush, stat_branches,
               stat_mispredicts
    );

    modport slave (
        input  in_valid, in_pc, in_imm, in_rs1, in_funct3, in_is_branch, in_is_jal,
               in_is_jalr, in_comp, in_pred_taken, in_pred_target, out_ready,
        output in_ready, out_valid, out_taken, out_target, out_link, out_illegal,
               out_misalign, redirect_valid, redirect_pc, flush, stat_branches,
               stat_mispredicts
    );
endinterface

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - Branch/jump resolution stage with mispredict redirect and flush.
// Optional counters enabled by BRANCH_STATS_EN.
module branch_resolve #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic            clk,
    input logic            rst_n,
    branch_resolve_if.slave bus
);
    localparam logic [1:0] COMP_EQ = 2'd0;
    localparam logic [1:0] COMP_LE = 2'd1;
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    typedef enum logic [0:0] {ST_RUN, ST_FLUSH} state_t;

    state_t      state_q;
    logic [3:0]  flush_cnt_q;
    logic        out_valid_q;
    logic        out_taken_q;
    logic [31:0] out_target_q;
    logic [31:0] out_link_q;
    logic        out_illegal_q;
    logic        out_misalign_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;

    logic        in_ready;
    logic        accept;
    logic        any_ctrl;
    logic        br_taken;
    logic        illegal_d;
    logic        taken_d;
    logic [31:0] link_d;
    logic [31:0] pc_imm;
    logic [31:0] rs1_imm;
    logic [31:0] jump_target;
    logic [31:0] target_d;
    logic        mispredict_d;

    assign in_ready = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign any_ctrl = bus.in_is_branch || bus.in_is_jal || bus.in_is_jalr;

    // Comparator has already folded signed/unsigned into EQ/LE, so funct3[1] only marks illegal encodings.
    always_comb begin
        br_taken  = 1'b0;
        illegal_d = 1'b0;
        case (bus.in_funct3)
            3'b000:         br_taken = (bus.in_comp == COMP_EQ);
            3'b001:         br_taken = (bus.in_comp != COMP_EQ);
            3'b100, 3'b110: br_taken = (bus.in_comp == COMP_LE);
            3'b101, 3'b111: br_taken = (bus.in_comp != COMP_LE);
            default:        illegal_d = bus.in_is_branch;
        endcase
    end

    assign link_d       = bus.in_pc + 32'd4;
    assign pc_imm       = bus.in_pc + bus.in_imm;
    assign rs1_imm      = bus.in_rs1 + bus.in_imm;
    assign jump_target  = bus.in_is_jalr ? (rs1_imm & ~32'd1) : pc_imm;
    assign taken_d      = bus.in_is_jal || bus.in_is_jalr || (bus.in_is_branch && br_taken);
    assign target_d     = taken_d ? jump_target : link_d;
    assign mispredict_d = any_ctrl &&
                          ((taken_d != bus.in_pred_taken) ||
                           (taken_d && (target_d != bus.in_pred_target)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_RUN;
            flush_cnt_q      <= 4'd0;
            out_valid_q      <= 1'b0;
            out_taken_q      <= 1'b0;
            out_target_q     <= 32'd0;
            out_link_q       <= 32'd0;
            out_illegal_q    <= 1'b0;
            out_misalign_q   <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            if (accept) begin
                out_valid_q    <= 1'b1;
                out_taken_q    <= taken_d;
                out_target_q   <= target_d;
                out_link_q     <= link_d;
                out_illegal_q  <= illegal_d;
                out_misalign_q <= taken_d && target_d[1];
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            redirect_valid_q <= accept && mispredict_d;
            if (accept && mispredict_d) begin
                redirect_pc_q <= target_d;
            end

            case (state_q)
                ST_RUN: begin
                    if (accept && mispredict_d) begin
                        state_q     <= ST_FLUSH;
                        flush_cnt_q <= FLUSH_INIT;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q <= 4'd1) begin
                        state_q     <= ST_RUN;
                        flush_cnt_q <= 4'd0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q     <= ST_RUN;
                    flush_cnt_q <= 4'd0;
                end
            endcase
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_taken      = out_taken_q;
    assign bus.out_target     = out_target_q;
    assign bus.out_link       = out_link_q;
    assign bus.out_illegal    = out_illegal_q;
    assign bus.out_misalign   = out_misalign_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush          = (state_q == ST_FLUSH);

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q <= 32'd0;
            stat_mp_q <= 32'd0;
        end else begin
            if (accept && any_ctrl && (stat_br_q != 32'hFFFF_FFFF)) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (accept && mispredict_d && (stat_mp_q != 32'hFFFF_FFFF)) begin
                stat_mp_q <= stat_mp_q + 32'd1;
            end
        end
    end

    assign bus.stat_branches    = stat_br_q;
    assign bus.stat_mispredicts = stat_mp_q;
`else
    assign bus.stat_branches    = 32'd0;
    assign bus.stat_mispredicts = 32'd0;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - Scoreboard bench for branch_resolve.
module tb_branch_resolve;
    localparam logic [1:0] COMP_EQ = 2'd0;
    localparam logic [1:0] COMP_LE = 2'd1;
    localparam logic [1:0] COMP_GE = 2'd2;
    localparam logic [2:0] K_BR    = 3'b100;
    localparam logic [2:0] K_JAL   = 3'b010;
    localparam logic [2:0] K_JALR  = 3'b001;
    localparam logic [2:0] K_NONE  = 3'b000;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [31:0] link;
        logic        illegal;
        logic        misalign;
        logic        mis;
        logic [31:0] rpc;
        logic        ctrl;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   exp_br;
    int   exp_mp;
    bit   rand_en;
    exp_t        exp_q[$];
    logic [31:0] rdr_q[$];

    branch_resolve_if bus ();

    branch_resolve #(.FLUSH_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] pc, imm, rs1, input logic [2:0] f3,
                                   input logic [2:0] kind, input logic [1:0] comp,
                                   input logic pred, input logic [31:0] ptgt);
        exp_t e;
        logic [31:0] tgt;
        e = '0;
        e.link = pc + 32'd4;
        e.ctrl = (kind != K_NONE);
        tgt    = pc + imm;
        if (kind == K_JAL) begin
            e.taken = 1'b1;
        end else if (kind == K_JALR) begin
            e.taken = 1'b1;
            tgt     = (rs1 + imm) & 32'hFFFF_FFFE;
        end else if (kind == K_BR) begin
            if (f3 == 3'b000)                    e.taken = (comp == COMP_EQ);
            else if (f3 == 3'b001)               e.taken = (comp != COMP_EQ);
            else if (f3 == 3'b100 || f3 == 3'b110) e.taken = (comp == COMP_LE);
            else if (f3 == 3'b101 || f3 == 3'b111) e.taken = (comp != COMP_LE);
            else                                 e.illegal = 1'b1;
        end
        e.target   = e.taken ? tgt : pc + 32'd4;
        e.misalign = e.taken && e.target[1];
        e.mis      = e.ctrl && ((e.taken != pred) || (e.taken && e.target != ptgt));
        e.rpc      = e.target;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive(input logic [31:0] pc, imm, rs1, input logic [2:0] f3,
                         input logic [2:0] kind, input logic [1:0] comp,
                         input logic pred, input logic [31:0] ptgt);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        bus.in_pc          = pc;
        bus.in_imm         = imm;
        bus.in_rs1         = rs1;
        bus.in_funct3      = f3;
        bus.in_is_branch   = kind[2];
        bus.in_is_jal      = kind[1];
        bus.in_is_jalr     = kind[0];
        bus.in_comp        = comp;
        bus.in_pred_taken  = pred;
        bus.in_pred_target = ptgt;
        bus.in_valid       = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
        end else begin
            e = model(pc, imm, rs1, f3, kind, comp, pred, ptgt);
            exp_q.push_back(e);
            if (e.mis) rdr_q.push_back(e.rpc);
            if (e.ctrl) exp_br++;
            if (e.mis) exp_mp++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd0, 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_taken",    {31'd0, bus.out_taken},    {31'd0, e.taken});
                    check("out_target",   bus.out_target,            e.target);
                    check("out_link",     bus.out_link,              e.link);
                    check("out_illegal",  {31'd0, bus.out_illegal},  {31'd0, e.illegal});
                    check("out_misalign", {31'd0, bus.out_misalign}, {31'd0, e.misalign});
                end
            end
            if (bus.redirect_valid) begin
                if (rdr_q.size() == 0) check("redirect_unexpected", 32'd0, 32'd1);
                else check("redirect_pc", bus.redirect_pc, rdr_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_en) bus.out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_br  = 0;
        exp_mp  = 0;
        rand_en = 1'b0;
        rst_n   = 1'b0;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_imm = '0; bus.in_rs1 = '0;
        bus.in_funct3 = '0; bus.in_is_branch = 1'b0; bus.in_is_jal = 1'b0;
        bus.in_is_jalr = 1'b0; bus.in_comp = '0; bus.in_pred_taken = 1'b0;
        bus.in_pred_target = '0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid},      32'd0);
        check("rst_flush",     {31'd0, bus.flush},          32'd0);
        check("rst_redirect",  {31'd0, bus.redirect_valid}, 32'd0);
        check("rst_target",    bus.out_target,              32'd0);
        check("rst_stat_br",   bus.stat_branches,           32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // BEQ mispredict: redirect pulse, flush exactly two cycles.
        drive(32'h100, 32'h20, 32'h0, 3'b000, K_BR, COMP_EQ, 1'b0, 32'h0);
        check("beq_redirect_rise", {31'd0, bus.redirect_valid}, 32'd1);
        check("beq_flush_c1",      {31'd0, bus.flush},          32'd1);
        check("beq_in_ready_c1",   {31'd0, bus.in_ready},       32'd0);
        check("beq_out_target",    bus.out_target,              32'h120);
        step();
        check("beq_redirect_fall", {31'd0, bus.redirect_valid}, 32'd0);
        check("beq_flush_c2",      {31'd0, bus.flush},          32'd1);
        check("beq_in_ready_c2",   {31'd0, bus.in_ready},       32'd0);
        step();
        check("beq_flush_end",     {31'd0, bus.flush},          32'd0);
        check("beq_in_ready_end",  {31'd0, bus.in_ready},       32'd1);

        drive(32'h200, 32'hFFFF_FFF8, 32'h0, 3'b110, K_BR, COMP_LE, 1'b1, 32'h1F8);
        check("bltu_no_flush", {31'd0, bus.flush}, 32'd0);
        drive(32'h300, 32'h40, 32'h0, 3'b101, K_BR, COMP_EQ, 1'b1, 32'h340);
        check("bge_no_flush", {31'd0, bus.flush}, 32'd0);
        drive(32'h300, 32'h40, 32'h0, 3'b101, K_BR, COMP_LE, 1'b1, 32'h340);
        drive(32'h400, 32'h4, 32'h1003, 3'b000, K_JALR, COMP_EQ, 1'b1, 32'h1000);
        check("jalr_misalign", {31'd0, bus.out_misalign}, 32'd1);
        drive(32'h480, 32'h10, 32'h0, 3'b001, K_BR, COMP_GE, 1'b1, 32'h490);
        drive(32'h4A0, 32'h10, 32'h0, 3'b100, K_BR, COMP_GE, 1'b0, 32'h0);
        drive(32'h4C0, 32'h10, 32'h0, 3'b010, K_BR, COMP_EQ, 1'b0, 32'h0);
        drive(32'h4E0, 32'h10, 32'h0, 3'b011, K_BR, COMP_LE, 1'b1, 32'h4F0);
        drive(32'hFFFF_FFF0, 32'h20, 32'h0, 3'b000, K_JAL, COMP_EQ, 1'b1, 32'h10);
        drive(32'h700, 32'h10, 32'h0, 3'b000, K_NONE, COMP_EQ, 1'b1, 32'h710);
        repeat (4) step();

        // Backpressure then back-to-back accept.
        bus.out_ready = 1'b0;
        drive(32'h500, 32'h10, 32'h0, 3'b000, K_BR, COMP_EQ, 1'b1, 32'h510);
        for (int i = 0; i < 3; i++) begin
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_out_target", bus.out_target, 32'h510);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        drive(32'h600, 32'h100, 32'h0, 3'b000, K_JAL, COMP_EQ, 1'b1, 32'h700);
        check("b2b_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("b2b_out_target", bus.out_target, 32'h700);

        rand_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  kind;
            logic [31:0] pc, imm, ptgt;
            exp_t        e;
            case ($urandom_range(0, 3))
                0:       kind = K_JAL;
                1:       kind = K_JALR;
                2:       kind = K_NONE;
                default: kind = K_BR;
            endcase
            pc   = $urandom & 32'hFFFF_FFFC;
            imm  = $urandom_range(0, 255) - 32'd128;
            ptgt = $urandom;
            e = model(pc, imm, pc, 3'($urandom), kind, 2'($urandom_range(0, 2)), 1'b1, 32'h0);
            if ($urandom_range(0, 1) == 1) ptgt = e.target;
            drive(pc, imm, pc, 3'($urandom), kind, 2'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)), ptgt);
        end
        rand_en = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && (exp_q.size() != 0 || bus.flush); i++) step();
        repeat (2) step();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("rdr_drained", 32'(rdr_q.size()), 32'd0);

`ifdef BRANCH_STATS_EN
        check("stat_branches",    bus.stat_branches,    32'(exp_br));
        check("stat_mispredicts", bus.stat_mispredicts, 32'(exp_mp));
`else
        check("stat_branches_off",    bus.stat_branches,    32'd0);
        check("stat_mispredicts_off", bus.stat_mispredicts, 32'd0);
`endif

        // Reset in the first flush cycle.
        drive(32'h800, 32'h20, 32'h0, 3'b000, K_BR, COMP_EQ, 1'b0, 32'h0);
        check("mid_flush_flush", {31'd0, bus.flush}, 32'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        rdr_q.delete();
        exp_br = 0;
        exp_mp = 0;
        check("mid_rst_flush",     {31'd0, bus.flush},          32'd0);
        check("mid_rst_redirect",  {31'd0, bus.redirect_valid}, 32'd0);
        check("mid_rst_out_valid", {31'd0, bus.out_valid},      32'd0);
        check("mid_rst_stat_br",   bus.stat_branches,           32'd0);
        check("mid_rst_stat_mp",   bus.stat_mispredicts,        32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
